dbus_arbiter: RTL

Two-requester arbiter and sequencer for the shared peripheral data bus behind the MEM stage. Requester 0 is the core MEM stage (MMIO loads/stores); requester 1 is the debugger/DMA port. It grants the bus round-robin and drives one valid/ready transaction at a time. It returns read data or a timeout error to the granted requester and produces the core stall that holds MEM while its access is outstanding.

---
 rtl/dbus_arbiter_pkg.sv | 27 ++
 rtl/dbus_arbiter_rr_pick2.sv | 13 +
 rtl/dbus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the peripheral data-bus arbiter: FSM states, the latched
// request record and a request-detect helper.
package dbus_arbiter_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TYPE_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    typedef struct packed {
        logic [TYPE_W-1:0] load_type;
        logic [TYPE_W-1:0] store_type;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dbus_req_t;

    function automatic logic has_req(input logic [TYPE_W-1:0] load_type,
                                     input logic [TYPE_W-1:0] store_type);
        return (|load_type) | (|store_type);
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    assign any = |req;
    assign gnt = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/dbus_arbiter.sv
// Arbitrates the MEM stage (requester 0) and the debug/DMA port (requester 1)
// onto the shared peripheral bus, one valid/ready transaction at a time.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0][TYPE_W-1:0] r_load_type,
    input  logic [1:0][TYPE_W-1:0] r_store_type,
    input  logic [1:0][ADDR_W-1:0] r_addr,
    input  logic [1:0][DATA_W-1:0] r_wdata,
    output logic [1:0]             r_done,
    output logic                   r_err,
    output logic [DATA_W-1:0]      r_rdata,
    output logic                   core_stall,
    output logic                   b_valid,
    output logic [ADDR_W-1:0]      b_addr,
    output logic [DATA_W-1:0]      b_wdata,
    output logic [TYPE_W-1:0]      b_load_type,
    output logic [TYPE_W-1:0]      b_store_type,
    input  logic                   b_ready,
    input  logic [DATA_W-1:0]      b_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              last_q;
    logic              gnt_q;
    dbus_req_t         req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [1:0] req;
    logic       pick_gnt;
    logic       pick_any;

    assign req[0] = has_req(r_load_type[0], r_store_type[0]);
    assign req[1] = has_req(r_load_type[1], r_store_type[1]);

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    // NOTE: b_valid and r_done decode the state register directly, so the
    // asynchronous reset drops them at once instead of at the next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        b_valid = 1'b0;
        r_done  = 2'b00;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) state_d = ARB_BUSY;
            end
            ARB_BUSY: begin
                b_valid = 1'b1;
                if (b_ready || (cnt_q == CNT_LAST)) state_d = ARB_DONE;
            end
            ARB_DONE: begin
                r_done[gnt_q] = 1'b1;
                state_d       = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Request inputs are only looked at in IDLE; after the grant the latched
    // copy drives the bus, so a withdrawn request still runs to completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        gnt_q  <= pick_gnt;
                        last_q <= pick_gnt;
                        req_q  <= '{load_type:  r_load_type[pick_gnt],
                                    store_type: r_store_type[pick_gnt],
                                    addr:       r_addr[pick_gnt],
                                    wdata:      r_wdata[pick_gnt]};
                        cnt_q  <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (b_ready) begin
                        rdata_q <= (|req_q.load_type) ? b_rdata : '0;
                        err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign b_addr       = req_q.addr;
    assign b_wdata      = req_q.wdata;
    assign b_load_type  = req_q.load_type;
    assign b_store_type = req_q.store_type;
    assign r_rdata      = rdata_q;
    assign r_err        = err_q;
    assign core_stall   = req[0] & ~r_done[0];

endmodule
